wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 108 ++++++++++
 tb/tb_wb_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back-latched 31x DATA_W register file: writes park in a one-entry latch for a
// cycle before committing, with read bypass from the latch and a same-cycle RAW stall flag.
module wb_regfile_rdport #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]             ra_i,
  input  logic [31:0][DATA_W-1:0] rf_i,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_addr_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  input  logic                   we_i,
  input  logic [4:0]             wa_i,
  output logic [DATA_W-1:0]      rd_o,
  output logic                   hit_o
);
  always_comb begin
    rd_o = rf_i[ra_i];
    if (ra_i == 5'd0)
      rd_o = '0;
    else if (wb_valid_i && (wb_addr_i == ra_i))
      rd_o = wb_data_i;
  end

  // Only the incoming instruction's write can collide; a latched write is bypassed instead.
  assign hit_o = we_i && (wa_i != 5'd0) && (ra_i == wa_i);
endmodule

module wb_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_in,
  input  logic [4:0]        wa_in,
  input  logic [DATA_W-1:0] wd_in,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              stall,
  output logic              wb_valid
);
  localparam int NUM_RD = 2;

  logic [31:1][DATA_W-1:0] mem_q;
  logic [31:0][DATA_W-1:0] rf_view;
  logic                    wb_valid_q, wb_valid_d;
  logic [4:0]              wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]       wb_data_q, wb_data_d;

  logic [NUM_RD-1:0][4:0]        ra_arr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_arr;
  logic [NUM_RD-1:0]             hit_arr;

  always_comb begin
    wb_valid_d = we_in && (wa_in != 5'd0);
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wb_valid_d) begin
      wb_addr_d = wa_in;
      wb_data_d = wd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Commit of the old latch happens on the same edge that loads the next one.
  for (genvar i = 1; i < 32; i++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        mem_q[i] <= '0;
      else if (wb_valid_q && (wb_addr_q == 5'(i)))
        mem_q[i] <= wb_data_q;
    end
  end

  assign rf_view = {mem_q, {DATA_W{1'b0}}};
  assign ra_arr  = {ra2, ra1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rdport #(.DATA_W(DATA_W)) u_rd (
      .ra_i       (ra_arr[p]),
      .rf_i       (rf_view),
      .wb_valid_i (wb_valid_q),
      .wb_addr_i  (wb_addr_q),
      .wb_data_i  (wb_data_q),
      .we_i       (we_in),
      .wa_i       (wa_in),
      .rd_o       (rd_arr[p]),
      .hit_o      (hit_arr[p])
    );
  end

  assign rd1      = rd_arr[0];
  assign rd2      = rd_arr[1];
  assign stall    = |hit_arr;
  assign wb_valid = wb_valid_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an architectural model: register array plus
// one pending write that becomes visible to reads immediately and lands in the array one edge later.
module tb_wb_regfile;
  localparam int DW = 32;

  logic          clk, reset, we_in, stall, wb_valid;
  logic [4:0]    wa_in, ra1, ra2;
  logic [DW-1:0] wd_in, rd1, rd2;

  int vectors = 0;
  int errs    = 0;

  logic [DW-1:0] m [32];
  logic          m_v;
  logic [4:0]    m_a;
  logic [DW-1:0] m_d;

  wb_regfile #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .we_in(we_in), .wa_in(wa_in), .wd_in(wd_in),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .stall(stall), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (m_v && m_a == ra) return m_d;
    return m[ra];
  endfunction

  function automatic logic exp_stall();
    return we_in && wa_in != 0 && (ra1 == wa_in || ra2 == wa_in);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = '0;
    m_v = 0; m_a = 0; m_d = '0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    we_in = we; wa_in = wa; wd_in = wd; ra1 = a1; ra2 = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (m_v) m[m_a] = m_d;
      m_v = we_in && wa_in != 0;
      if (m_v) begin m_a = wa_in; m_d = wd_in; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 5'd4, 32'h55, 5'd4, 5'd0);
    vectors++;
    if (stall !== 1'b1) begin errs++; $display("FAIL rst_stall got %b want 1", stall); end
    vectors++;
    if (rd1 !== '0 || wb_valid !== 1'b0) begin
      errs++; $display("FAIL rst_hold rd1=%h wb_valid=%b want 0/0", rd1, wb_valid);
    end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      drive(0, 5'd0, '0, 5'(i), 5'(31 - i));
      vectors++;
      if (rd1 !== '0 || rd2 !== '0 || wb_valid !== 1'b0) begin
        errs++; $display("FAIL rst_read a=%0d rd1=%h rd2=%h wbv=%b want 0", i, rd1, rd2, wb_valid);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, '0, 5'd5, 5'd0);
    vectors++;
    if (rd1 !== 32'hDEADBEEF || stall !== 1'b0 || wb_valid !== 1'b1) begin
      errs++; $display("FAIL bypass rd1=%h stall=%b wbv=%b want deadbeef/0/1", rd1, stall, wb_valid);
    end
    tick();
    vectors++;
    if (rd1 !== 32'hDEADBEEF || wb_valid !== 1'b0) begin
      errs++; $display("FAIL array5 rd1=%h wbv=%b want deadbeef/0", rd1, wb_valid);
    end
  endtask

  task automatic test_wa0();
    drive(1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    vectors++;
    if (rd1 !== '0 || stall !== 1'b0) begin
      errs++; $display("FAIL wa0 rd1=%h stall=%b want 0/0", rd1, stall);
    end
    tick();
    drive(0, 5'd0, '0, 5'd0, 5'd5);
    vectors++;
    if (wb_valid !== 1'b0 || rd2 !== exp_rd(5'd5)) begin
      errs++; $display("FAIL wa0_latch wbv=%b rd2=%h want 0/%h", wb_valid, rd2, exp_rd(5'd5));
    end
  endtask

  task automatic test_stall();
    drive(1, 5'd7, 32'hCAFE0007, 5'd0, 5'd7);
    vectors++;
    if (stall !== 1'b1) begin errs++; $display("FAIL stall got %b want 1", stall); end
    tick();
    drive(0, 5'd7, '0, 5'd0, 5'd7);
    vectors++;
    if (stall !== 1'b0 || rd2 !== 32'hCAFE0007) begin
      errs++; $display("FAIL stall_bypass stall=%b rd2=%h want 0/cafe0007", stall, rd2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 5'd9, 32'h1, 5'd0, 5'd0);
    tick();
    drive(1, 5'd9, 32'h2, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, '0, 5'd9, 5'd9);
    vectors++;
    if (rd1 !== 32'h2) begin errs++; $display("FAIL b2b_bypass rd1=%h want 2", rd1); end
    tick();
    vectors++;
    if (rd2 !== 32'h2 || wb_valid !== 1'b0) begin
      errs++; $display("FAIL b2b_array rd2=%h wbv=%b want 2/0", rd2, wb_valid);
    end
  endtask

  task automatic test_reset_pending();
    drive(1, 5'd3, 32'hAA, 5'd0, 5'd0);
    tick();
    #2 reset = 1;
    #1 reset = 0;
    model_clear();
    drive(0, 5'd0, '0, 5'd3, 5'd9);
    vectors++;
    if (rd1 !== '0 || rd2 !== '0 || wb_valid !== 1'b0) begin
      errs++; $display("FAIL rst_pend rd1=%h rd2=%h wbv=%b want 0", rd1, rd2, wb_valid);
    end
    tick();
    vectors++;
    if (rd1 !== '0) begin errs++; $display("FAIL rst_pend_commit rd1=%h want 0", rd1); end
  endtask

  task automatic test_random(input int n);
    logic [4:0] wa, a1, a2;
    for (int c = 0; c < n; c++) begin
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
      a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
      a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        drive(1'($urandom), wa, $urandom, a1, a2);
        model_clear();
        vectors++;
        if (rd1 !== '0 || rd2 !== '0 || wb_valid !== 1'b0 || stall !== exp_stall()) begin
          errs++; $display("FAIL rnd_rst c=%0d rd1=%h rd2=%h wbv=%b stall=%b", c, rd1, rd2, wb_valid, stall);
        end
        reset = 0;
      end
      drive(1'($urandom), wa, $urandom, a1, a2);
      vectors++;
      if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || stall !== exp_stall() || wb_valid !== m_v) begin
        errs++;
        $display("FAIL rnd c=%0d rd1=%h/%h rd2=%h/%h stall=%b/%b wbv=%b/%b (got/want)",
                 c, rd1, exp_rd(a1), rd2, exp_rd(a2), stall, exp_stall(), wb_valid, m_v);
      end
      tick();
    end
  endtask

  initial begin
    clk = 0; reset = 1;
    we_in = 0; wa_in = 0; wd_in = '0; ra1 = 0; ra2 = 0;
    model_clear();
    #12;
    test_reset();
    test_bypass();
    test_wa0();
    test_stall();
    test_back_to_back();
    test_reset_pending();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
